render_sequencer_n: RTL and testbench
=====================================

Name: render_sequencer_n

Overview:
Parametrised top-level game/render control FSM for the DE1 Bomberman design, driving the shared draw datapath through title, stage, per-frame redraw and win screens. It generalises the two-player controller to NUM_PLAYERS players and NUM_BOMBS bomb slots. It skips dead players and inactive bomb slots. It reports a latched winner, and it generates its own frame tick and sprite refresh strobe.

Parameters:
NUM_PLAYERS, 2, number of players (2..4); PID_W = 2
NUM_BOMBS, 6, bomb slots drawn per frame (1..8); BID_W = 3
LIVES_W, 2, width of each player's lives field; max lives = 2^LIVES_W-1
TICK_DIV, 833333, clock cycles per frame tick (50 MHz -> 60 Hz)
FRAMES_PER_REFRESH, 15, frame ticks per refresh pulse

Ports:
clock  in  1  system clock, 50 MHz
resetn  in  1  asynchronous, active-low reset
lives  in  NUM_PLAYERS*LIVES_W  packed lives; player p at [p*LIVES_W +: LIVES_W]
bomb_active  in  NUM_BOMBS  1 = slot holds a live bomb
go  in  1  user start/continue
finished  in  1  datapath done with current draw/copy op
all_tiles_drawn  in  1  tile counter wrapped
memory_select  out  2  0 title, 1 stage, 2 win, 3 sprite/back buffer
copy_enable, tc_enable, player_reset, tile_reset, print_screen  out  1 each  datapath strobes
draw_stage, draw_tile, draw_explosion, draw_bomb, check_player, draw_player, draw_hp  out  1 each  op selects
player_id  out  PID_W  player being processed
bomb_id  out  BID_W  bomb slot being processed
hp_id  out  LIVES_W  heart index being drawn
corner_id  out  2  sprite corner being checked
refresh  out  1  one-cycle pulse every FRAMES_PER_REFRESH ticks
winner_valid  out  1  winner_id is meaningful
winner_id  out  PID_W  lowest-index surviving player at game over

Behaviour:
- Reset (resetn=0, async): state LOAD_TITLE. All counters, ids, refresh, winner_valid and winner_id are 0. Outputs are the LOAD_TITLE decode. A reset mid-draw aborts immediately.
- All outputs are combinational decode of state, except counters and the winner registers. Default for every strobe is 0; memory_select defaults to 0.
- Screen states:
  - LOAD_TITLE (sel0, copy, draw_stage; clears winner) -> DISPLAY_TITLE on finished.
  - DISPLAY_TITLE (print_screen) -> TITLE on finished.
  - TITLE -> LOAD_STAGE on go.
  - LOAD_STAGE (sel1, copy, draw_stage) -> DISPLAY_STAGE on finished.
  - DISPLAY_STAGE (print_screen, player_reset, tile_reset; clears tick/frame/ids) -> DRAW_TILE on finished.
- Tile loop:
  - DRAW_TILE (sel3, copy, draw_tile) -> DRAW_EXPLOSION on finished.
  - DRAW_EXPLOSION (sel3, copy, draw_explosion) -> UPDATE_TILE on finished.
  - UPDATE_TILE (tc_enable) -> DRAW_BOMB if all_tiles_drawn, else DRAW_TILE.
- Bomb loop:
  - DRAW_BOMB: if bomb_active[bomb_id], assert sel3/copy/draw_bomb and wait for finished. If inactive, assert nothing and leave next cycle.
  - DRAW_BOMB -> UPDATE_BOMB.
  - UPDATE_BOMB: if bomb_id==NUM_BOMBS-1, set bomb_id to 0 and go to PLAYER_START. Otherwise bomb_id+1 and go to DRAW_BOMB.
- Player loop (player_id starts at 0):
  - PLAYER_START: lives[p]==0 -> NEXT_PLAYER (dead, not drawn). Otherwise corner_id=0, hp_id=0 -> CHECK_CORNER.
  - CHECK_CORNER (check_player, one cycle) -> UPDATE_CORNER.
  - UPDATE_CORNER: corner_id==3 -> DRAW_PLAYER with corner_id 0; else corner_id+1 -> CHECK_CORNER.
  - DRAW_PLAYER (sel3, copy, draw_player) -> DRAW_HP on finished.
  - DRAW_HP (sel3, copy, draw_hp) -> UPDATE_HP on finished.
  - UPDATE_HP: hp_id+1 >= lives[p] (current value; covers lives dropping mid-loop) -> NEXT_PLAYER with hp_id 0. Otherwise hp_id+1 -> DRAW_HP.
  - NEXT_PLAYER: player_id==NUM_PLAYERS-1 -> GAME_IDLE with player_id 0. Otherwise player_id+1 -> PLAYER_START.
- Tick:
  - The tick counter runs 0..TICK_DIV-1 in every state from DRAW_TILE through GAME_IDLE. It holds in all other states.
  - tick = (count==TICK_DIV-1).
  - GAME_IDLE waits for tick, then goes to UPDATE_STAGE.
  - The frame counter increments on each tick and wraps at FRAMES_PER_REFRESH-1.
  - refresh = tick AND frame==FRAMES_PER_REFRESH-1, exactly one clock wide.
- UPDATE_STAGE (print_screen):
  - alive = number of players with nonzero lives, evaluated every cycle.
  - If alive<=1: latch winner_valid = (alive==1) and winner_id = lowest alive index, then go to LOAD_WIN. Game over takes priority over finished.
  - Else if finished -> DRAW_TILE. Else stay.
- Win screens:
  - LOAD_WIN (sel2, copy, draw_stage) -> DISPLAY_WIN on finished.
  - DISPLAY_WIN (print_screen) -> WIN on finished.
  - WIN -> LOAD_TITLE on go. winner_id/winner_valid hold until LOAD_TITLE.
- Illegal state -> LOAD_TITLE.

Test Plan:
- Reset, then finished pulses and go, with TICK_DIV=4 and FRAMES_PER_REFRESH=2 -> state sequence title -> stage -> DRAW_TILE. memory_select is 0, then 1, then 3 in the draw states. refresh pulses once every 8 clocks of game states.
- bomb_active=6'b000101 -> draw_bomb asserted only for bomb_id 0 and 2. Inactive slots take one DRAW_BOMB cycle plus UPDATE_BOMB. bomb_id returns to 0.
- NUM_PLAYERS=4, lives={0,3,0,1} (p3..p0) -> check_player pulses 4x for players 0 and 2 only. draw_hp: 1 heart for p0, 3 for p2. Players 1 and 3 are skipped.
- In UPDATE_STAGE, lives change so only p2 is nonzero -> LOAD_WIN, winner_valid=1, winner_id=2 held through WIN. Cleared in LOAD_TITLE after go.
- All lives 0 in UPDATE_STAGE with finished=1 -> LOAD_WIN (not DRAW_TILE), winner_valid=0.
- Assert resetn=0 mid DRAW_HP with hp_id=1 -> asynchronously LOAD_TITLE, all ids 0, refresh 0, winner cleared.

Source files
------------

// File: rtl/render_sequencer_n.sv
// rtl/render_sequencer_n.sv - game/render control FSM for N players and N bomb slots
// Sequences title, stage, per-frame redraw and win screens; owns the frame tick and refresh strobe.
module render_sequencer_n #(
  parameter int NUM_PLAYERS        = 2,
  parameter int NUM_BOMBS          = 6,
  parameter int LIVES_W            = 2,
  parameter int TICK_DIV           = 833333,
  parameter int FRAMES_PER_REFRESH = 15,
  localparam int PID_W             = 2,
  localparam int BID_W             = 3
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NUM_PLAYERS*LIVES_W-1:0] lives,
  input  logic [NUM_BOMBS-1:0]           bomb_active,
  input  logic                           go,
  input  logic                           finished,
  input  logic                           all_tiles_drawn,
  output logic [1:0]                     memory_select,
  output logic                           copy_enable,
  output logic                           tc_enable,
  output logic                           player_reset,
  output logic                           tile_reset,
  output logic                           print_screen,
  output logic                           draw_stage,
  output logic                           draw_tile,
  output logic                           draw_explosion,
  output logic                           draw_bomb,
  output logic                           check_player,
  output logic                           draw_player,
  output logic                           draw_hp,
  output logic [PID_W-1:0]               player_id,
  output logic [BID_W-1:0]               bomb_id,
  output logic [LIVES_W-1:0]             hp_id,
  output logic [1:0]                     corner_id,
  output logic                           refresh,
  output logic                           winner_valid,
  output logic [PID_W-1:0]               winner_id
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FRAME_W = (FRAMES_PER_REFRESH > 1) ? $clog2(FRAMES_PER_REFRESH) : 1;

  // Order matters: DRAW_TILE..GAME_IDLE is the contiguous range where the tick counter runs.
  typedef enum logic [4:0] {
    LOAD_TITLE, DISPLAY_TITLE, TITLE, LOAD_STAGE, DISPLAY_STAGE,
    DRAW_TILE, DRAW_EXPLOSION, UPDATE_TILE, DRAW_BOMB, UPDATE_BOMB,
    PLAYER_START, CHECK_CORNER, UPDATE_CORNER, DRAW_PLAYER, DRAW_HP,
    UPDATE_HP, NEXT_PLAYER, GAME_IDLE, UPDATE_STAGE, LOAD_WIN,
    DISPLAY_WIN, WIN
  } state_t;

  state_t              state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [FRAME_W-1:0]  frame_cnt;
  logic                tick_run, tick, frame_last;
  logic [LIVES_W-1:0]  life [4];
  logic [LIVES_W-1:0]  cur_lives;
  logic [7:0]          bomb_ext;
  logic [2:0]          alive;
  logic [PID_W-1:0]    first_alive;
  logic                hp_done, bomb_last, player_last;

  always_comb begin
    for (int p = 0; p < 4; p++) life[p] = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) life[p] = lives[p*LIVES_W +: LIVES_W];
  end

  // Scan high to low so the last hit is the lowest surviving index.
  always_comb begin
    alive       = '0;
    first_alive = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (life[p] != '0) begin
        alive       = alive + 3'd1;
        first_alive = PID_W'(p);
      end
    end
  end

  assign cur_lives   = life[player_id];
  assign bomb_ext    = 8'(bomb_active);
  assign hp_done     = ({1'b0, hp_id} + (LIVES_W+1)'(1)) >= {1'b0, cur_lives};
  assign bomb_last   = (bomb_id == BID_W'(NUM_BOMBS - 1));
  assign player_last = (player_id == PID_W'(NUM_PLAYERS - 1));
  assign tick_run    = (state >= DRAW_TILE) && (state <= GAME_IDLE);
  assign tick        = tick_run && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign frame_last  = (frame_cnt == FRAME_W'(FRAMES_PER_REFRESH - 1));
  assign refresh     = tick && frame_last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= LOAD_TITLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt     <= '0;
      frame_cnt    <= '0;
      player_id    <= '0;
      bomb_id      <= '0;
      hp_id        <= '0;
      corner_id    <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
    end else begin
      if (state == DISPLAY_STAGE) begin
        tick_cnt  <= '0;
        frame_cnt <= '0;
        player_id <= '0;
        bomb_id   <= '0;
        hp_id     <= '0;
        corner_id <= '0;
      end else if (tick_run) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
      end
      case (state)
        UPDATE_BOMB:   bomb_id   <= bomb_last ? '0 : bomb_id + 1'b1;
        PLAYER_START:  if (cur_lives != '0) begin
                         corner_id <= '0;
                         hp_id     <= '0;
                       end
        UPDATE_CORNER: corner_id <= corner_id + 2'd1;
        UPDATE_HP:     hp_id     <= hp_done ? '0 : hp_id + 1'b1;
        NEXT_PLAYER:   player_id <= player_last ? '0 : player_id + 1'b1;
        default: ;
      endcase
      if (state == LOAD_TITLE) begin
        winner_valid <= 1'b0;
        winner_id    <= '0;
      end else if (state == UPDATE_STAGE && alive <= 3'd1) begin
        winner_valid <= (alive == 3'd1);
        winner_id    <= first_alive;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    memory_select  = 2'd0;
    copy_enable    = 1'b0;
    tc_enable      = 1'b0;
    player_reset   = 1'b0;
    tile_reset     = 1'b0;
    print_screen   = 1'b0;
    draw_stage     = 1'b0;
    draw_tile      = 1'b0;
    draw_explosion = 1'b0;
    draw_bomb      = 1'b0;
    check_player   = 1'b0;
    draw_player    = 1'b0;
    draw_hp        = 1'b0;
    case (state)
      LOAD_TITLE: begin
        copy_enable = 1'b1;
        draw_stage  = 1'b1;
        if (finished) state_nxt = DISPLAY_TITLE;
      end
      DISPLAY_TITLE: begin
        print_screen = 1'b1;
        if (finished) state_nxt = TITLE;
      end
      TITLE: if (go) state_nxt = LOAD_STAGE;
      LOAD_STAGE: begin
        memory_select = 2'd1;
        copy_enable   = 1'b1;
        draw_stage    = 1'b1;
        if (finished) state_nxt = DISPLAY_STAGE;
      end
      DISPLAY_STAGE: begin
        print_screen = 1'b1;
        player_reset = 1'b1;
        tile_reset   = 1'b1;
        if (finished) state_nxt = DRAW_TILE;
      end
      DRAW_TILE: begin
        memory_select = 2'd3;
        copy_enable   = 1'b1;
        draw_tile     = 1'b1;
        if (finished) state_nxt = DRAW_EXPLOSION;
      end
      DRAW_EXPLOSION: begin
        memory_select  = 2'd3;
        copy_enable    = 1'b1;
        draw_explosion = 1'b1;
        if (finished) state_nxt = UPDATE_TILE;
      end
      UPDATE_TILE: begin
        tc_enable = 1'b1;
        state_nxt = all_tiles_drawn ? DRAW_BOMB : DRAW_TILE;
      end
      DRAW_BOMB: begin
        if (bomb_ext[bomb_id]) begin
          memory_select = 2'd3;
          copy_enable   = 1'b1;
          draw_bomb     = 1'b1;
          if (finished) state_nxt = UPDATE_BOMB;
        end else begin
          state_nxt = UPDATE_BOMB;
        end
      end
      UPDATE_BOMB:   state_nxt = bomb_last ? PLAYER_START : DRAW_BOMB;
      PLAYER_START:  state_nxt = (cur_lives == '0) ? NEXT_PLAYER : CHECK_CORNER;
      CHECK_CORNER: begin
        check_player = 1'b1;
        state_nxt    = UPDATE_CORNER;
      end
      UPDATE_CORNER: state_nxt = (corner_id == 2'd3) ? DRAW_PLAYER : CHECK_CORNER;
      DRAW_PLAYER: begin
        memory_select = 2'd3;
        copy_enable   = 1'b1;
        draw_player   = 1'b1;
        if (finished) state_nxt = DRAW_HP;
      end
      DRAW_HP: begin
        memory_select = 2'd3;
        copy_enable   = 1'b1;
        draw_hp       = 1'b1;
        if (finished) state_nxt = UPDATE_HP;
      end
      UPDATE_HP:     state_nxt = hp_done ? NEXT_PLAYER : DRAW_HP;
      NEXT_PLAYER:   state_nxt = player_last ? GAME_IDLE : PLAYER_START;
      GAME_IDLE:     if (tick) state_nxt = UPDATE_STAGE;
      UPDATE_STAGE: begin
        print_screen = 1'b1;
        if (alive <= 3'd1) state_nxt = LOAD_WIN;
        else if (finished) state_nxt = DRAW_TILE;
      end
      LOAD_WIN: begin
        memory_select = 2'd2;
        copy_enable   = 1'b1;
        draw_stage    = 1'b1;
        if (finished) state_nxt = DISPLAY_WIN;
      end
      DISPLAY_WIN: begin
        print_screen = 1'b1;
        if (finished) state_nxt = WIN;
      end
      WIN: if (go) state_nxt = LOAD_TITLE;
      default: state_nxt = LOAD_TITLE;
    endcase
  end

endmodule

// File: tb/tb_render_sequencer_n.sv
// tb/tb_render_sequencer_n.sv - directed self-checking bench for render_sequencer_n
module tb_render_sequencer_n;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] lives;
  logic [5:0] bomb_active;
  logic       go, finished, all_tiles_drawn;
  logic [1:0] memory_select;
  logic       copy_enable, tc_enable, player_reset, tile_reset, print_screen;
  logic       draw_stage, draw_tile, draw_explosion, draw_bomb, check_player, draw_player, draw_hp;
  logic [1:0] player_id;
  logic [2:0] bomb_id;
  logic [1:0] hp_id;
  logic [1:0] corner_id;
  logic       refresh, winner_valid;
  logic [1:0] winner_id;

  int errors = 0;
  int checks = 0;
  int chk_cnt[4];
  int hp_cnt[4];
  int bomb_mask, bomb_draws, id1_cycles, id5_cycles, refresh_cnt, refresh_bad, mem_bad, frame_len;

  always #5 clock = ~clock;

  render_sequencer_n #(
    .NUM_PLAYERS(4), .NUM_BOMBS(6), .LIVES_W(2), .TICK_DIV(4), .FRAMES_PER_REFRESH(2)
  ) dut (
    .clock(clock), .resetn(resetn), .lives(lives), .bomb_active(bomb_active),
    .go(go), .finished(finished), .all_tiles_drawn(all_tiles_drawn),
    .memory_select(memory_select), .copy_enable(copy_enable), .tc_enable(tc_enable),
    .player_reset(player_reset), .tile_reset(tile_reset), .print_screen(print_screen),
    .draw_stage(draw_stage), .draw_tile(draw_tile), .draw_explosion(draw_explosion),
    .draw_bomb(draw_bomb), .check_player(check_player), .draw_player(draw_player),
    .draw_hp(draw_hp), .player_id(player_id), .bomb_id(bomb_id), .hp_id(hp_id),
    .corner_id(corner_id), .refresh(refresh), .winner_valid(winner_valid), .winner_id(winner_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From the first DRAW_TILE cycle (k=0), run to UPDATE_STAGE tallying strobes per cycle.
  task automatic run_frame();
    int k;
    for (int p = 0; p < 4; p++) begin chk_cnt[p] = 0; hp_cnt[p] = 0; end
    bomb_mask = 0; bomb_draws = 0; id1_cycles = 0; id5_cycles = 0;
    refresh_cnt = 0; refresh_bad = 0; mem_bad = 0;
    k = 0;
    while (!print_screen && k < 300) begin
      if (check_player) chk_cnt[player_id]++;
      if (draw_hp) hp_cnt[player_id]++;
      if (draw_bomb) begin bomb_mask |= (1 << bomb_id); bomb_draws++; end
      if (bomb_id == 3'd1) id1_cycles++;
      if (bomb_id == 3'd5) id5_cycles++;
      if (refresh) begin refresh_cnt++; if (k % 8 != 7) refresh_bad++; end
      if (copy_enable && memory_select != 2'd3) mem_bad++;
      step();
      k++;
    end
    frame_len = k;
    check("reach_update_stage", print_screen, 1);
  endtask

  // From LOAD_TITLE with finished held high, walk to the first DRAW_TILE.
  task automatic start_game();
    step(); step();
    go = 1'b1; step(); go = 1'b0;
    step(); step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0; go = 1'b0; finished = 1'b0; all_tiles_drawn = 1'b1;
    lives = 8'h31; bomb_active = 6'b000101;
    #12;
    check("rst_memsel", memory_select, 0);
    check("rst_copy_stage", {copy_enable, draw_stage, print_screen}, 3'b110);
    check("rst_ids", {player_id, bomb_id, hp_id, corner_id}, 0);
    check("rst_refresh", refresh, 0);
    check("rst_winner", {winner_valid, winner_id}, 0);

    @(posedge clock); #1 resetn = 1'b1;
    step();
    check("ltitle_hold", {memory_select, copy_enable}, 3'b001);
    finished = 1'b1; step(); finished = 1'b0;
    check("disp_title", {print_screen, copy_enable}, 2'b10);
    finished = 1'b1; step(); finished = 1'b0;
    check("title", {copy_enable, print_screen, draw_stage, memory_select}, 0);
    step();
    check("title_wait_go", {copy_enable, print_screen, draw_stage}, 0);
    go = 1'b1; step(); go = 1'b0;
    check("load_stage", {memory_select, copy_enable, draw_stage}, 4'b0111);
    finished = 1'b1; step(); finished = 1'b0;
    check("disp_stage", {print_screen, player_reset, tile_reset}, 3'b111);
    finished = 1'b1; step();
    check("draw_tile", {memory_select, copy_enable, draw_tile}, 4'b1111);

    run_frame();
    check("frame_len", frame_len, 52);
    check("chk_p0", chk_cnt[0], 4);
    check("chk_p1", chk_cnt[1], 0);
    check("chk_p2", chk_cnt[2], 4);
    check("chk_p3", chk_cnt[3], 0);
    check("hp_p0", hp_cnt[0], 1);
    check("hp_p2", hp_cnt[2], 3);
    check("hp_p1p3", hp_cnt[1] + hp_cnt[3], 0);
    check("bomb_mask", bomb_mask, 6'b000101);
    check("bomb_draws", bomb_draws, 2);
    check("bomb1_cycles", id1_cycles, 2);
    check("bomb5_cycles", id5_cycles, 2);
    check("refresh_cnt", refresh_cnt, 6);
    check("refresh_phase", refresh_bad, 0);
    check("draw_memsel", mem_bad, 0);
    check("us_ids", {bomb_id, player_id}, 0);

    finished = 1'b0; step();
    check("us_stay", {print_screen, draw_tile, memory_select}, 4'b1000);
    finished = 1'b1; step();
    check("us_to_tile", {draw_tile, memory_select}, 3'b111);
    run_frame();

    finished = 1'b0; lives = 8'h30; step();
    check("lwin_decode", {memory_select, copy_enable, draw_stage}, 4'b1011);
    check("lwin_winner", {winner_valid, winner_id}, 3'b110);
    finished = 1'b1; step(); finished = 1'b0;
    check("dwin", {print_screen, winner_valid, winner_id}, 4'b1110);
    finished = 1'b1; step(); finished = 1'b0;
    check("win", {print_screen, winner_valid, winner_id}, 4'b0110);
    step();
    check("win_hold", {winner_valid, winner_id}, 3'b110);
    go = 1'b1; step(); go = 1'b0;
    check("ltitle2", {memory_select, draw_stage}, 3'b001);
    step();
    check("winner_cleared", {winner_valid, winner_id}, 0);

    lives = 8'h31; finished = 1'b1;
    start_game();
    check("game2_tile", draw_tile, 1);
    run_frame();
    lives = 8'h00; step();
    check("all_dead_memsel", {memory_select, draw_tile}, 3'b100);
    check("all_dead_winner", {winner_valid, winner_id}, 0);

    step(); step();
    lives = 8'h31; go = 1'b1; step(); go = 1'b0;
    start_game();
    n = 0;
    while (!(draw_hp && hp_id == 2'd1) && n < 300) begin step(); n++; end
    check("hp1_found", {draw_hp, hp_id}, 3'b101);
    check("hp1_player", player_id, 2);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_decode", {memory_select, copy_enable, draw_stage, draw_hp}, 5'b00110);
    check("async_rst_ids", {player_id, bomb_id, hp_id, corner_id}, 0);
    check("async_rst_misc", {refresh, winner_valid, winner_id}, 0);
    step();
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
